// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bundle of hazard control, instruction memory and decode signals
//   master: hazard unit / memory / decode side (drives controls and instr_f)
//   slave : fetch stage (drives pc_f, fetch_fault_f and the fetch/decode register outputs)
interface fetch_stage_if;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        pc_src;
   logic [31:0] pc_target;
   logic [31:0] pc_f;
   logic [31:0] instr_f;
   logic        fetch_fault_f;
   logic [31:0] instr_d;
   logic [31:0] pc_plus8_d;
   logic        valid_d;
   modport master (
      output stall_f, stall_d, flush_d, pc_src, pc_target, instr_f,
      input  pc_f, fetch_fault_f, instr_d, pc_plus8_d, valid_d
   );
   modport slave (
      input  stall_f, stall_d, flush_d, pc_src, pc_target, instr_f,
      output pc_f, fetch_fault_f, instr_d, pc_plus8_d, valid_d
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: ARM instruction fetch - PC, imem address, fetch/decode register
//   clk, reset         : clock, asynchronous active-high reset
//   bus.stall_f/pc_src : hold PC / redirect to pc_target (redirect wins)
//   bus.stall_d/flush_d: hold / bubble the fetch/decode register (flush wins)
//   bus.pc_f, instr_f  : imem address out, combinational read data in
//   bus.fetch_fault_f  : pc_f beyond populated imem
//   bus.instr_d, pc_plus8_d, valid_d : registered outputs to decode
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000,
   parameter int unsigned IMEM_WORDS = 32
) (
   input logic          clk,
   input logic          reset,
   fetch_stage_if.slave bus
);
   logic [31:0] pc_q, pc_d, ir_q, ir_d, pc8_q, pc8_d;
   logic        vld_q, vld_d, fault;
   assign fault = {2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS);
   always_comb begin
      pc_d  = bus.pc_src ? {bus.pc_target[31:2], 2'b00} : bus.stall_f ? pc_q : pc_q + 32'd4;
      // faulting fetches select the NOP before the register so an X word never gets captured
      ir_d  = bus.flush_d ? NOP_INSTR : bus.stall_d ? ir_q : fault ? NOP_INSTR : bus.instr_f;
      pc8_d = bus.flush_d ? 32'd0 : bus.stall_d ? pc8_q : pc_q + 32'd8;
      vld_d = !bus.flush_d && (bus.stall_d ? vld_q : !fault);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         ir_q  <= NOP_INSTR;
         pc8_q <= 32'd0;
         vld_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         pc8_q <= pc8_d;
         vld_q <= vld_d;
      end
   end
   assign bus.pc_f          = pc_q;
   assign bus.fetch_fault_f = fault;
   assign bus.instr_d       = ir_q;
   assign bus.pc_plus8_d    = pc8_q;
   assign bus.valid_d       = vld_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'hE1A0_0000;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic        v;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   fetch_stage_if bus ();
   fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] mem(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction
   // imem model: 32 populated words, X outside so captured X would be visible
   assign bus.instr_f = (bus.pc_f < 32'h80) ? mem(int'(bus.pc_f[6:2])) : 32'hxxxx_xxxx;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pc8, input logic v);
      exp_t e;
      sb.push_back('{pc, instr, pc8, v});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".pc_f"}, bus.pc_f, e.pc);
      chk({tag, ".instr_d"}, bus.instr_d, e.instr);
      chk({tag, ".pc_plus8_d"}, bus.pc_plus8_d, e.pc8);
      chk({tag, ".valid_d"}, {31'd0, bus.valid_d}, {31'd0, e.v});
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, ".pc_f"}, bus.pc_f, 32'd0);
      chk({tag, ".instr_d"}, bus.instr_d, NOP);
      chk({tag, ".pc_plus8_d"}, bus.pc_plus8_d, 32'd0);
      chk({tag, ".valid_d"}, {31'd0, bus.valid_d}, 32'd0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.stall_f = 0; bus.stall_d = 0; bus.flush_d = 0; bus.pc_src = 0; bus.pc_target = 0;
      #3 reset = 1;
      #1 chk_reset("rst_async");
      @(negedge clk); @(negedge clk);
      reset = 0;
      #1 chk("rst_fault", {31'd0, bus.fetch_fault_f}, 32'd0);
      step("seq0", 32'h4, mem(0), 32'h8, 1);
      step("seq1", 32'h8, mem(1), 32'hC, 1);
      step("seq2", 32'hC, mem(2), 32'h10, 1);
      step("seq3", 32'h10, mem(3), 32'h14, 1);
      bus.pc_src = 1; bus.pc_target = 32'h7;
      step("redir", 32'h4, mem(4), 32'h18, 1);
      bus.stall_f = 1;
      step("redir_stall", 32'h4, mem(1), 32'hC, 1);
      bus.pc_src = 0; bus.stall_d = 1;
      step("stall0", 32'h4, mem(1), 32'hC, 1);
      step("stall1", 32'h4, mem(1), 32'hC, 1);
      bus.flush_d = 1;
      step("flush_stall", 32'h4, NOP, 32'h0, 0);
      bus.flush_d = 0; bus.stall_d = 0;
      step("stallf_only", 32'h4, mem(1), 32'hC, 1);
      bus.stall_f = 0; bus.pc_src = 1; bus.pc_target = 32'h80;
      step("to_fault", 32'h80, mem(1), 32'hC, 1);
      chk("fault_hi", {31'd0, bus.fetch_fault_f}, 32'd1);
      bus.pc_src = 0;
      step("fault_cap", 32'h84, NOP, 32'h88, 0);
      bus.pc_src = 1; bus.pc_target = 32'hFFFF_FFFC;
      step("to_top", 32'hFFFF_FFFC, NOP, 32'h8C, 0);
      chk("fault_top", {31'd0, bus.fetch_fault_f}, 32'd1);
      bus.pc_src = 0;
      step("wrap", 32'h0, NOP, 32'h4, 0);
      chk("fault_wrap", {31'd0, bus.fetch_fault_f}, 32'd0);
      step("after_wrap", 32'h4, mem(0), 32'h8, 1);
      bus.flush_d = 1;
      step("flush", 32'h8, NOP, 32'h0, 0);
      bus.flush_d = 0;
      step("post_flush", 32'hC, mem(2), 32'h10, 1);
      bus.pc_src = 1; bus.pc_target = 32'h2B;
      step("redir_only", 32'h28, mem(3), 32'h14, 1);
      bus.pc_src = 0;
      step("redir_seq", 32'h2C, mem(10), 32'h30, 1);
      #2 reset = 1;
      #1 chk_reset("rst_mid");
      @(negedge clk);
      reset = 0;
      step("rst_seq", 32'h4, mem(0), 32'h8, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
